dma_ctrl: RTL and testbench
===========================

DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: dsaddr, ddaddr  in  BUS_ADDR_WIDTH(10)  source and destination start addresses.
REQ-004 SHALL have port: dcount  in  BUS_ADDR_WIDTH  Block-mode transfer count; 0 treated as 1.
REQ-005 SHALL have port: dmode  in  2  Single=00, Block=01, Demand=10; 11 treated as Single.
REQ-006 SHALL have port: dreq_  in  1  transfer request, active-low, sampled on clk.
REQ-007 SHALL have port: eop_  out  1  end-of-process, active-low, one-cycle pulse.
REQ-008 SHALL have ports: breq_ out 1 bus request, active-low; bgrt_ in 1 bus grant, active-low.
REQ-009 SHALL have ports: addr out BUS_ADDR_WIDTH; odata out DATA_WIDTH(8) write data; idata in DATA_WIDTH read data; rw_ out 1 (Read=1, Write=0).
REQ-010 SHALL have port: busy  out  1  high from accepted request until return to IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, RD, LAT, WR, NXT, DONE.
REQ-012 IDLE: dreq_ low at a rising edge -> latch dsaddr, ddaddr, dcount, dmode into internal registers; go to REQ; later changes to these inputs ignored.
REQ-013 REQ: breq_=0; stay until bgrt_=0, then go to RD.
REQ-014 RD: addr=source register, rw_=Read; next LAT.
REQ-015 LAT: keep RD outputs; capture idata into data register (memory read latency exactly one cycle); next WR.
REQ-016 WR: addr=destination register, odata=data register, rw_=Write for exactly one cycle; next NXT.
REQ-017 NXT: source+1, destination+1 (mod 2^10, 0x3FF wraps to 0x000), remaining count-1.
REQ-018 NXT, Single: go to DONE after one transfer.
REQ-019 NXT, Block: go to RD while remaining count nonzero (bus held, breq_ stays 0), else DONE.
REQ-020 NXT, Demand: count exhausted -> DONE; else dreq_=0 -> RD; else release bus and return to IDLE without eop_, keeping addresses/count so a later dreq_ resumes the transfer.
REQ-021 DONE: eop_=0 for one cycle, breq_=1; next IDLE.
REQ-022 When not in RD/LAT/WR: addr=0, odata=0, rw_=Read.
REQ-023 If bgrt_ goes high while in RD, LAT or WR: freeze state, force rw_=Read, and resume the same step once bgrt_=0.
REQ-024 dreq_ while busy (other than the Demand continuation of REQ-020) SHALL be ignored.
REQ-025 Total latency for Single with immediate grant: 6 cycles from dreq_ sample edge to eop_ low.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, breq_=1, eop_=1, rw_=Read, addr=0, odata=0, busy=0, and clear all registers.
REQ-027 Reset mid-transfer SHALL abort with no further write and no eop_ pulse.

Structure
REQ-028 Shared header define.h SHALL hold BUS_ADDR_WIDTH, DATA_WIDTH, Enable_/Disable_, Read/Write, mode codes Single/Block/Demand, and FSM state encodings.
REQ-029 A sub-module dma_addr_gen SHALL hold the source/destination address registers and remaining-count register, with load and step controls.

Verification
REQ-030 Single: mem[0x150]=0x99, dsaddr=0x150, ddaddr=0x160, dreq_ pulse -> one write of 0x99 to 0x160, eop_ pulse, mem[0x160]=0x99.
REQ-031 Block: dcount=4, 0x100..0x103 = 11,22,33,44 -> 0x200..0x203 equal; breq_ low continuously; exactly one eop_.
REQ-032 Wrap: Block, dsaddr=0x3FE, ddaddr=0x0F0, dcount=3 -> reads 0x3FE, 0x3FF, 0x000.
REQ-033 Demand: dcount=5, dreq_ held for 2 transfers then released -> bus released, no eop_; dreq_ reasserted -> remaining 3 transfers run, then eop_.
REQ-034 Grant delay/revoke: bgrt_ held high 3 cycles, then revoked during WR for 2 cycles -> no write while revoked, and the correct data is written after regrant.
REQ-035 Reset asserted during LAT of a Block transfer -> all outputs return to reset values immediately; destination is unchanged beyond completed writes.

Source files
------------

// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA controller: bus widths, active-low levels,
// bus direction codes, transfer mode codes and FSM state encodings.
package dma_ctrl_pkg;

  localparam int BUS_ADDR_WIDTH = 10;
  localparam int DATA_WIDTH     = 8;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [1:0] SINGLE = 2'b00;
  localparam logic [1:0] BLOCK  = 2'b01;
  localparam logic [1:0] DEMAND = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    LAT  = 3'd3,
    WR   = 3'd4,
    NXT  = 3'd5,
    DONE = 3'd6
  } state_t;

  // The reserved mode code behaves as Single.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? SINGLE : mode;
  endfunction

endpackage

// File: rtl/dma_ctrl_addr_gen.sv
// Source/destination address and remaining-count registers for the DMA
// controller; loaded at transfer start and stepped once per completed transfer.
module dma_addr_gen
  import dma_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      step,
  input  logic [BUS_ADDR_WIDTH-1:0] dsaddr,
  input  logic [BUS_ADDR_WIDTH-1:0] ddaddr,
  input  logic [BUS_ADDR_WIDTH-1:0] dcount,
  output logic [BUS_ADDR_WIDTH-1:0] src,
  output logic [BUS_ADDR_WIDTH-1:0] dst,
  output logic                      last
);

  logic [BUS_ADDR_WIDTH-1:0] src_reg;
  logic [BUS_ADDR_WIDTH-1:0] dst_reg;
  logic [BUS_ADDR_WIDTH-1:0] cnt_reg;

  // Addresses wrap naturally at the register width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_reg <= '0;
      dst_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      src_reg <= dsaddr;
      dst_reg <= ddaddr;
      cnt_reg <= (dcount == '0) ? BUS_ADDR_WIDTH'(1) : dcount;
    end else if (step) begin
      src_reg <= src_reg + 1'b1;
      dst_reg <= dst_reg + 1'b1;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign src  = src_reg;
  assign dst  = dst_reg;
  assign last = (cnt_reg == BUS_ADDR_WIDTH'(1));

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA controller with Single, Block and
// Demand modes, bus request/grant handshake and an end-of-process pulse.
module dma_ctrl
  import dma_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_ADDR_WIDTH-1:0] dsaddr,
  input  logic [BUS_ADDR_WIDTH-1:0] ddaddr,
  input  logic [BUS_ADDR_WIDTH-1:0] dcount,
  input  logic [1:0]                dmode,
  input  logic                      dreq_,
  output logic                      eop_,
  output logic                      breq_,
  input  logic                      bgrt_,
  output logic [BUS_ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]     odata,
  input  logic [DATA_WIDTH-1:0]     idata,
  output logic                      rw_,
  output logic                      busy
);

  state_t                    state_reg, state_next;
  logic [1:0]                mode_reg;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic                      resume_reg;
  logic                      load, step, capture, resume_set, resume_clr;
  logic [BUS_ADDR_WIDTH-1:0] src, dst;
  logic                      last;

  dma_addr_gen u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .dsaddr (dsaddr),
    .ddaddr (ddaddr),
    .dcount (dcount),
    .src    (src),
    .dst    (dst),
    .last   (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= SINGLE;
      data_reg   <= '0;
      resume_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load)    mode_reg <= norm_mode(dmode);
      if (capture) data_reg <= idata;
      if (resume_set)      resume_reg <= 1'b1;
      else if (resume_clr) resume_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    resume_set = 1'b0;
    resume_clr = 1'b0;
    breq_      = DISABLE_;
    eop_       = DISABLE_;
    rw_        = READ;
    addr       = '0;
    odata      = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // A paused Demand transfer resumes with its saved addresses and count.
        if (dreq_ == ENABLE_) begin
          state_next = REQ;
          load       = !resume_reg;
          resume_clr = 1'b1;
        end
      end
      REQ: begin
        breq_ = ENABLE_;
        if (bgrt_ == ENABLE_) state_next = RD;
      end
      RD: begin
        breq_ = ENABLE_;
        addr  = src;
        if (bgrt_ == ENABLE_) state_next = LAT;
      end
      LAT: begin
        breq_ = ENABLE_;
        addr  = src;
        if (bgrt_ == ENABLE_) begin
          capture    = 1'b1;
          state_next = WR;
        end
      end
      WR: begin
        breq_ = ENABLE_;
        addr  = dst;
        odata = data_reg;
        if (bgrt_ == ENABLE_) begin
          rw_        = WRITE;
          state_next = NXT;
        end
      end
      NXT: begin
        breq_ = ENABLE_;
        step  = 1'b1;
        case (mode_reg)
          BLOCK:   state_next = last ? DONE : RD;
          DEMAND: begin
            if (last)                  state_next = DONE;
            else if (dreq_ == ENABLE_) state_next = RD;
            else begin
              state_next = IDLE;
              resume_set = 1'b1;
            end
          end
          default: state_next = DONE;
        endcase
      end
      DONE: begin
        eop_       = ENABLE_;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed testbench for dma_ctrl with a one-cycle-latency memory model.
module tb_dma_ctrl;

  logic       clk, reset;
  logic [9:0] dsaddr, ddaddr, dcount, addr;
  logic [1:0] dmode;
  logic       dreq_, eop_, breq_, bgrt_, rw_, busy;
  logic [7:0] odata, idata;

  logic [7:0] mem [0:1023];
  logic       pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  logic       smp_rw, smp_eop, smp_busy, smp_breq, smp_bgrt;
  logic [9:0] smp_addr;
  logic [7:0] smp_odata;

  int wr_cnt = 0, eop_cnt = 0, gap_cnt = 0, bad_wr = 0;
  int n_checks = 0, n_fail = 0;

  dma_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .dsaddr (dsaddr),
    .ddaddr (ddaddr),
    .dcount (dcount),
    .dmode  (dmode),
    .dreq_  (dreq_),
    .eop_   (eop_),
    .breq_  (breq_),
    .bgrt_  (bgrt_),
    .addr   (addr),
    .odata  (odata),
    .idata  (idata),
    .rw_    (rw_),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus outputs are sampled mid-cycle so the memory never races the DUT.
  always @(negedge clk) begin
    #4;
    smp_rw    = rw_;
    smp_addr  = addr;
    smp_odata = odata;
    smp_eop   = eop_;
    smp_busy  = busy;
    smp_breq  = breq_;
    smp_bgrt  = bgrt_;
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (smp_rw === 1'b0) begin
      mem[smp_addr] <= smp_odata;
      wr_cnt++;
      if (smp_bgrt !== 1'b0) bad_wr++;
      $display("write addr=%03h data=%02h", smp_addr, smp_odata);
    end
    idata <= mem[smp_addr];
    if (smp_eop === 1'b0) eop_cnt++;
    if (smp_busy === 1'b1 && smp_breq === 1'b1 && smp_eop === 1'b1) gap_cnt++;
  end

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents a request for one sample edge, then scrambles the inputs.
  task automatic start(input logic [9:0] sa, input logic [9:0] da, input logic [9:0] cnt,
                       input logic [1:0] md, input logic hold);
    dsaddr = sa; ddaddr = da; dcount = cnt; dmode = md; dreq_ = 1'b0;
    @(negedge clk);
    if (!hold) dreq_ = 1'b1;
    dsaddr = 10'h3C3; ddaddr = 10'h3C3; dcount = 10'd9; dmode = 2'b01;
  endtask

  task automatic wait_eop(input int budget, output int cyc);
    cyc = 0;
    while (eop_ !== 1'b0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_checks += 6;
    if (breq_ !== 1'b1) begin n_fail++; $display("FAIL reset_breq got=%b exp=1", breq_); end
    if (eop_  !== 1'b1) begin n_fail++; $display("FAIL reset_eop got=%b exp=1", eop_); end
    if (rw_   !== 1'b1) begin n_fail++; $display("FAIL reset_rw got=%b exp=1", rw_); end
    if (addr  !== 10'h000) begin n_fail++; $display("FAIL reset_addr got=%h exp=000", addr); end
    if (odata !== 8'h00) begin n_fail++; $display("FAIL reset_odata got=%h exp=00", odata); end
    if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    int cyc, w0, e0;
    poke(10'h150, 8'h99);
    poke(10'h160, 8'h00);
    w0 = wr_cnt; e0 = eop_cnt;
    start(10'h150, 10'h160, 10'd0, 2'b00, 1'b0);
    cyc = 1;
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    if (breq_ !== 1'b0) begin n_fail++; $display("FAIL single_breq got=%b exp=0", breq_); end
    while (eop_ !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        n_checks += 2;
        if (addr !== 10'h150) begin n_fail++; $display("FAIL single_rd_addr got=%h exp=150", addr); end
        if (rw_ !== 1'b1) begin n_fail++; $display("FAIL single_rd_rw got=%b exp=1", rw_); end
      end
      if (cyc == 4) begin
        n_checks += 3;
        if (addr !== 10'h160) begin n_fail++; $display("FAIL single_wr_addr got=%h exp=160", addr); end
        if (rw_ !== 1'b0) begin n_fail++; $display("FAIL single_wr_rw got=%b exp=0", rw_); end
        if (odata !== 8'h99) begin n_fail++; $display("FAIL single_wr_data got=%h exp=99", odata); end
      end
    end
    n_checks++;
    if (cyc != 6) begin n_fail++; $display("FAIL single_latency got=%0d exp=6", cyc); end
    @(negedge clk);
    n_checks += 4;
    if (mem[10'h160] !== 8'h99) begin n_fail++; $display("FAIL single_mem got=%h exp=99", mem[10'h160]); end
    if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL single_writes got=%0d exp=1", wr_cnt - w0); end
    if (eop_cnt - e0 != 1) begin n_fail++; $display("FAIL single_eops got=%0d exp=1", eop_cnt - e0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_block;
    logic [7:0] exp_d [4];
    int cyc, w0, e0, g0;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      poke(10'h100 + 10'(i), exp_d[i]);
      poke(10'h200 + 10'(i), 8'h00);
    end
    w0 = wr_cnt; e0 = eop_cnt; g0 = gap_cnt;
    start(10'h100, 10'h200, 10'd4, 2'b01, 1'b0);
    repeat (4) @(negedge clk);
    dreq_ = 1'b0; dsaddr = 10'h150;
    @(negedge clk);
    dreq_ = 1'b1;
    wait_eop(80, cyc);
    n_checks++;
    if (eop_ !== 1'b0) begin n_fail++; $display("FAIL block_eop_seen got=%b exp=0", eop_); end
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[10'h200 + 10'(i)] !== exp_d[i]) begin
        n_fail++; $display("FAIL block_mem[%0d] got=%h exp=%h", i, mem[10'h200 + 10'(i)], exp_d[i]);
      end
    end
    n_checks += 4;
    if (wr_cnt - w0 != 4) begin n_fail++; $display("FAIL block_writes got=%0d exp=4", wr_cnt - w0); end
    if (eop_cnt - e0 != 1) begin n_fail++; $display("FAIL block_eops got=%0d exp=1", eop_cnt - e0); end
    if (gap_cnt - g0 != 0) begin n_fail++; $display("FAIL block_breq_gap got=%0d exp=0", gap_cnt - g0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL block_idle got=%b exp=0", busy); end
  endtask

  task automatic test_wrap;
    int cyc, w0;
    poke(10'h3FE, 8'hA1); poke(10'h3FF, 8'hB2); poke(10'h000, 8'hC3);
    poke(10'h0F0, 8'h00); poke(10'h0F1, 8'h00); poke(10'h0F2, 8'h00);
    w0 = wr_cnt;
    start(10'h3FE, 10'h0F0, 10'd3, 2'b01, 1'b0);
    wait_eop(60, cyc);
    @(negedge clk);
    n_checks += 4;
    if (mem[10'h0F0] !== 8'hA1) begin n_fail++; $display("FAIL wrap_mem0 got=%h exp=a1", mem[10'h0F0]); end
    if (mem[10'h0F1] !== 8'hB2) begin n_fail++; $display("FAIL wrap_mem1 got=%h exp=b2", mem[10'h0F1]); end
    if (mem[10'h0F2] !== 8'hC3) begin n_fail++; $display("FAIL wrap_mem2 got=%h exp=c3", mem[10'h0F2]); end
    if (wr_cnt - w0 != 3) begin n_fail++; $display("FAIL wrap_writes got=%0d exp=3", wr_cnt - w0); end
  endtask

  task automatic test_demand;
    logic [7:0] exp_d [5];
    int cyc, w0, e0, seen;
    exp_d = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    for (int i = 0; i < 5; i++) begin
      poke(10'h010 + 10'(i), exp_d[i]);
      poke(10'h020 + 10'(i), 8'h00);
    end
    w0 = wr_cnt; e0 = eop_cnt;
    start(10'h010, 10'h020, 10'd5, 2'b10, 1'b1);
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rw_ === 1'b0) seen++;
    end
    dreq_ = 1'b1;
    repeat (4) @(negedge clk);
    n_checks += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL demand_pause_busy got=%b exp=0", busy); end
    if (breq_ !== 1'b1) begin n_fail++; $display("FAIL demand_pause_breq got=%b exp=1", breq_); end
    if (wr_cnt - w0 != 2) begin n_fail++; $display("FAIL demand_pause_writes got=%0d exp=2", wr_cnt - w0); end
    if (eop_cnt - e0 != 0) begin n_fail++; $display("FAIL demand_pause_eops got=%0d exp=0", eop_cnt - e0); end
    if (mem[10'h022] !== 8'h00) begin n_fail++; $display("FAIL demand_pause_mem got=%h exp=00", mem[10'h022]); end
    dsaddr = 10'h3AA; ddaddr = 10'h3AB; dcount = 10'd1; dmode = 2'b00; dreq_ = 1'b0;
    wait_eop(80, cyc);
    dreq_ = 1'b1;
    n_checks++;
    if (eop_ !== 1'b0) begin n_fail++; $display("FAIL demand_eop_seen got=%b exp=0", eop_); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem[10'h020 + 10'(i)] !== exp_d[i]) begin
        n_fail++; $display("FAIL demand_mem[%0d] got=%h exp=%h", i, mem[10'h020 + 10'(i)], exp_d[i]);
      end
    end
    n_checks += 3;
    if (wr_cnt - w0 != 5) begin n_fail++; $display("FAIL demand_writes got=%0d exp=5", wr_cnt - w0); end
    if (eop_cnt - e0 != 1) begin n_fail++; $display("FAIL demand_eops got=%0d exp=1", eop_cnt - e0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL demand_idle got=%b exp=0", busy); end
  endtask

  task automatic test_grant;
    int cyc, w0;
    poke(10'h050, 8'h5A);
    poke(10'h060, 8'h00);
    w0 = wr_cnt;
    bgrt_ = 1'b1;
    start(10'h050, 10'h060, 10'd0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (breq_ !== 1'b0) begin n_fail++; $display("FAIL grant_wait_breq got=%b exp=0", breq_); end
    if (addr !== 10'h000) begin n_fail++; $display("FAIL grant_wait_addr got=%h exp=000", addr); end
    bgrt_ = 1'b0;
    cyc = 0;
    while (rw_ !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bgrt_ = 1'b1;
    #1;
    n_checks++;
    if (rw_ !== 1'b1) begin n_fail++; $display("FAIL grant_revoke_rw got=%b exp=1", rw_); end
    repeat (2) @(negedge clk);
    n_checks += 3;
    if (rw_ !== 1'b1) begin n_fail++; $display("FAIL grant_hold_rw got=%b exp=1", rw_); end
    if (addr !== 10'h060) begin n_fail++; $display("FAIL grant_hold_addr got=%h exp=060", addr); end
    if (wr_cnt - w0 != 0) begin n_fail++; $display("FAIL grant_hold_writes got=%0d exp=0", wr_cnt - w0); end
    bgrt_ = 1'b0;
    wait_eop(20, cyc);
    @(negedge clk);
    n_checks += 3;
    if (mem[10'h060] !== 8'h5A) begin n_fail++; $display("FAIL grant_mem got=%h exp=5a", mem[10'h060]); end
    if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL grant_writes got=%0d exp=1", wr_cnt - w0); end
    if (bad_wr != 0) begin n_fail++; $display("FAIL grant_revoked_writes got=%0d exp=0", bad_wr); end
  endtask

  task automatic test_modes;
    int cyc, w0;
    poke(10'h040, 8'h3C); poke(10'h048, 8'h00);
    poke(10'h070, 8'h77); poke(10'h071, 8'h78);
    poke(10'h078, 8'h00); poke(10'h079, 8'h00);
    w0 = wr_cnt;
    start(10'h040, 10'h048, 10'd0, 2'b01, 1'b0);
    wait_eop(30, cyc);
    @(negedge clk);
    n_checks += 2;
    if (mem[10'h048] !== 8'h3C) begin n_fail++; $display("FAIL count0_mem got=%h exp=3c", mem[10'h048]); end
    if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL count0_writes got=%0d exp=1", wr_cnt - w0); end
    w0 = wr_cnt;
    start(10'h070, 10'h078, 10'd3, 2'b11, 1'b0);
    wait_eop(30, cyc);
    repeat (3) @(negedge clk);
    n_checks += 3;
    if (mem[10'h078] !== 8'h77) begin n_fail++; $display("FAIL mode3_mem0 got=%h exp=77", mem[10'h078]); end
    if (mem[10'h079] !== 8'h00) begin n_fail++; $display("FAIL mode3_mem1 got=%h exp=00", mem[10'h079]); end
    if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL mode3_writes got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid;
    int cyc, hits, w0, e0;
    poke(10'h100, 8'h11); poke(10'h101, 8'h22);
    poke(10'h300, 8'h00); poke(10'h301, 8'h00);
    w0 = wr_cnt; e0 = eop_cnt;
    start(10'h100, 10'h300, 10'd4, 2'b01, 1'b0);
    hits = 0; cyc = 0;
    while (hits < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && rw_ === 1'b1 && addr === 10'h101) hits++;
    end
    reset = 1'b1;
    #1;
    n_checks += 6;
    if (breq_ !== 1'b1) begin n_fail++; $display("FAIL midrst_breq got=%b exp=1", breq_); end
    if (eop_ !== 1'b1) begin n_fail++; $display("FAIL midrst_eop got=%b exp=1", eop_); end
    if (rw_ !== 1'b1) begin n_fail++; $display("FAIL midrst_rw got=%b exp=1", rw_); end
    if (addr !== 10'h000) begin n_fail++; $display("FAIL midrst_addr got=%h exp=000", addr); end
    if (odata !== 8'h00) begin n_fail++; $display("FAIL midrst_odata got=%h exp=00", odata); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_checks += 4;
    if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL midrst_writes got=%0d exp=1", wr_cnt - w0); end
    if (eop_cnt - e0 != 0) begin n_fail++; $display("FAIL midrst_eops got=%0d exp=0", eop_cnt - e0); end
    if (mem[10'h300] !== 8'h11) begin n_fail++; $display("FAIL midrst_mem0 got=%h exp=11", mem[10'h300]); end
    if (mem[10'h301] !== 8'h00) begin n_fail++; $display("FAIL midrst_mem1 got=%h exp=00", mem[10'h301]); end
  endtask

  initial begin
    reset = 1'b1; dreq_ = 1'b1; bgrt_ = 1'b0;
    dsaddr = '0; ddaddr = '0; dcount = '0; dmode = 2'b00;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_single;
    test_block;
    test_wrap;
    test_demand;
    test_grant;
    test_modes;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
